// File: rtl/addr_cal_unit.sv
// -----------------------------------------------------------------------------
// addr_cal_unit
//
// Sprite pattern-memory address generator. For every pixel (hcount, vcount)
// it decides whether the pixel falls inside a visible sprite region and, if
// so, computes the pattern-memory address of the texel to fetch. Both outputs
// are registered, so they appear one clock after the inputs are sampled.
//
// Ports
//   clk           : sole clock, all state updates on the rising edge
//   reset         : synchronous, active-high reset
//   pattern_info  : [79:64] base_addr, [63:48] tile_w, [47:32] tile_h,
//                   [31:16] region_w, [15:0] region_h
//   sprite_info   : [31] visible, [30] flipped, [29:20] x origin,
//                   [19:10] y origin, [9:0] horizontal shift
//   hcount        : current pixel column
//   vcount        : current pixel row
//   addr_output   : registered pattern-memory address (0 when not valid)
//   valid         : registered "pixel inside a visible sprite region"
// -----------------------------------------------------------------------------
module addr_cal_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] pattern_info,
  input  logic [31:0] sprite_info,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_output,
  output logic        valid
);

  // Unpacked descriptor fields.
  logic [15:0] base_addr;
  logic [15:0] tile_w;
  logic [15:0] tile_h;
  logic [15:0] region_w;
  logic [15:0] region_h;
  logic        visible;
  logic        flipped;
  logic [9:0]  org_x;
  logic [9:0]  org_y;
  logic [9:0]  shift;

  assign base_addr = pattern_info[79:64];
  assign tile_w    = pattern_info[63:48];
  assign tile_h    = pattern_info[47:32];
  assign region_w  = pattern_info[31:16];
  assign region_h  = pattern_info[15:0];

  assign visible   = sprite_info[31];
  assign flipped   = sprite_info[30];
  assign org_x     = sprite_info[29:20];
  assign org_y     = sprite_info[19:10];
  assign shift     = sprite_info[9:0];

  // Combinational next-state values.
  logic        in_x;
  logic        in_y;
  logic        valid_next;
  logic [15:0] local_col;
  logic [15:0] local_row;
  logic [15:0] w_mask;
  logic [15:0] h_mask;
  logic [15:0] col_masked;
  logic [15:0] col;
  logic [15:0] row;
  logic [15:0] row_offset;
  logic [15:0] addr_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    in_x       = 1'b0;
    in_y       = 1'b0;
    valid_next = 1'b0;
    local_col  = '0;
    local_row  = '0;
    w_mask     = '0;
    h_mask     = '0;
    col_masked = '0;
    col        = '0;
    row        = '0;
    row_offset = '0;
    addr_next  = '0;

    // Region test in 17 bits. "hcount <= x + w - 1" is written as
    // "hcount < x + w", which is the same for integers and needs no
    // decrement, so region_w = 0 naturally yields an empty region.
    in_x = ({7'd0, hcount} >= {7'd0, org_x}) &&
           ({7'd0, hcount} <  ({7'd0, org_x} + {1'b0, region_w}));
    in_y = ({7'd0, vcount} >= {7'd0, org_y}) &&
           ({7'd0, vcount} <  ({7'd0, org_y} + {1'b0, region_h}));
    valid_next = visible && in_x && in_y;

    // Local coordinates, modulo 2^16.
    local_col = {6'd0, hcount} - {6'd0, org_x} + {6'd0, shift};
    local_row = {6'd0, vcount} - {6'd0, org_y};

    // Tile wrap by masking; non-power-of-two sizes use the same mask rule.
    w_mask     = tile_w - 16'd1;
    h_mask     = tile_h - 16'd1;
    col_masked = local_col & w_mask;
    col        = flipped ? (w_mask - col_masked) : col_masked;
    row        = local_row & h_mask;

    // Linear address, truncated to 16 bits.
    row_offset = row * tile_w;
    addr_next  = base_addr + row_offset + col;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_output <= 16'h0000;
      valid       <= 1'b0;
    end else begin
      valid       <= valid_next;
      addr_output <= valid_next ? addr_next : 16'h0000;
    end
  end

endmodule

// File: tb/tb_addr_cal_unit.sv
// -----------------------------------------------------------------------------
// tb_addr_cal_unit
//
// Directed bench for addr_cal_unit. Each task drives one scenario and checks
// the registered outputs one clock later against hand-computed values.
// -----------------------------------------------------------------------------
module tb_addr_cal_unit;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  int checks = 0;
  int errors = 0;

  // base 0, tile 16x16, region 650x32.
  localparam logic [79:0] PAT = {16'd0, 16'd16, 16'd16, 16'd650, 16'd32};

  addr_cal_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_sprite(input logic vis, input logic flip,
                                            input int x, input int y,
                                            input int sh);
    logic [9:0] xv, yv, sv;
    xv = x[9:0];
    yv = y[9:0];
    sv = sh[9:0];
    return {vis, flip, xv, yv, sv};
  endfunction

  // Drive inputs away from the active edge, then sample #1 after it.
  task automatic apply(input logic [31:0] spr, input int h, input int v);
    @(negedge clk);
    sprite_info = spr;
    hcount      = h[9:0];
    vcount      = v[9:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset        = 1'b1;
    pattern_info = PAT;
    sprite_info  = mk_sprite(1, 0, 0, 368, 0);
    hcount       = 10'd20;
    vcount       = 10'd370;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", valid);
    end
    checks++;
    if (addr_output !== 16'h0000) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", addr_output);
    end
    // Output must not change before the next edge after reset releases.
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_hold: got %b expected 0 before edge", valid);
    end
    // First edge after release reflects the inputs directly.
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd36) begin
      errors++;
      $display("FAIL reset_release: got valid=%b addr=%0d expected 1/36", valid, addr_output);
    end
  endtask

  task automatic test_basic;
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 370);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid: got %b expected 1", valid);
    end
    checks++;
    if (addr_output !== 16'd36) begin
      errors++;
      $display("FAIL basic_addr: got %0d expected 36", addr_output);
    end
  endtask

  task automatic test_flip;
    apply(mk_sprite(1, 1, 0, 368, 0), 20, 370);
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd43) begin
      errors++;
      $display("FAIL flip: got valid=%b addr=%0d expected 1/43", valid, addr_output);
    end
  endtask

  task automatic test_scroll;
    apply(mk_sprite(1, 0, 0, 368, 5), 20, 370);
    checks++;
    if (addr_output !== 16'd41) begin
      errors++;
      $display("FAIL scroll_5: got %0d expected 41", addr_output);
    end
    apply(mk_sprite(1, 0, 0, 368, 0), 0, 370);
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd32) begin
      errors++;
      $display("FAIL scroll_h0: got valid=%b addr=%0d expected 1/32", valid, addr_output);
    end
  endtask

  task automatic test_row_boundary;
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 399);
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd244) begin
      errors++;
      $display("FAIL row_last: got valid=%b addr=%0d expected 1/244", valid, addr_output);
    end
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 400);
    checks++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      errors++;
      $display("FAIL row_past: got valid=%b addr=%0d expected 0/0", valid, addr_output);
    end
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 367);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL row_before: got %b expected 0", valid);
    end
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 368);
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd4) begin
      errors++;
      $display("FAIL row_first: got valid=%b addr=%0d expected 1/4", valid, addr_output);
    end
  endtask

  task automatic test_col_boundary;
    // hcount 649: lc=649, col=9, row=2 -> 41.
    apply(mk_sprite(1, 0, 0, 368, 0), 649, 370);
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd41) begin
      errors++;
      $display("FAIL col_last: got valid=%b addr=%0d expected 1/41", valid, addr_output);
    end
    apply(mk_sprite(1, 0, 0, 368, 0), 650, 370);
    checks++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      errors++;
      $display("FAIL col_past: got valid=%b addr=%0d expected 0/0", valid, addr_output);
    end
    // Nonzero x: x=100, hcount=99 is left of region.
    apply(mk_sprite(1, 0, 100, 368, 0), 99, 370);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL col_left: got %b expected 0", valid);
    end
  endtask

  task automatic test_visibility;
    apply(mk_sprite(0, 0, 0, 368, 0), 20, 370);
    checks++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      errors++;
      $display("FAIL invisible: got valid=%b addr=%0d expected 0/0", valid, addr_output);
    end
  endtask

  task automatic test_zero_region;
    @(negedge clk);
    pattern_info = {16'd0, 16'd16, 16'd16, 16'd0, 16'd32};
    apply(mk_sprite(1, 0, 0, 368, 0), 0, 370);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_width: got %b expected 0", valid);
    end
    @(negedge clk);
    pattern_info = {16'd0, 16'd16, 16'd16, 16'd650, 16'd0};
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 368);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_height: got %b expected 0", valid);
    end
    @(negedge clk);
    pattern_info = PAT;
  endtask

  task automatic test_wrap_and_mask;
    // base 0xFFF0 + 36 wraps to 0x0014.
    @(negedge clk);
    pattern_info = {16'hFFF0, 16'd16, 16'd16, 16'd650, 16'd32};
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 370);
    checks++;
    if (addr_output !== 16'h0014) begin
      errors++;
      $display("FAIL base_wrap: got %h expected 0014", addr_output);
    end
    // tile_w 12 (mask 11): lc=20 -> col 0, row 2 -> 24; flipped col 11 -> 35.
    @(negedge clk);
    pattern_info = {16'd0, 16'd12, 16'd16, 16'd650, 16'd32};
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 370);
    checks++;
    if (addr_output !== 16'd24) begin
      errors++;
      $display("FAIL npot_mask: got %0d expected 24", addr_output);
    end
    apply(mk_sprite(1, 1, 0, 368, 0), 20, 370);
    checks++;
    if (addr_output !== 16'd35) begin
      errors++;
      $display("FAIL npot_flip: got %0d expected 35", addr_output);
    end
    @(negedge clk);
    pattern_info = PAT;
  endtask

  task automatic test_back_to_back;
    apply(mk_sprite(1, 0, 0, 368, 0), 20, 370);
    checks++;
    if (addr_output !== 16'd36) begin
      errors++;
      $display("FAIL stream_0: got %0d expected 36", addr_output);
    end
    // Reset asserted for one edge mid-stream overrides the computation.
    @(negedge clk);
    reset  = 1'b1;
    hcount = 10'd21;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b addr=%0d expected 0/0", valid, addr_output);
    end
    @(negedge clk);
    reset  = 1'b0;
    hcount = 10'd22;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || addr_output !== 16'd38) begin
      errors++;
      $display("FAIL resume: got valid=%b addr=%0d expected 1/38", valid, addr_output);
    end
    apply(mk_sprite(1, 0, 0, 368, 0), 23, 371);
    checks++;
    if (addr_output !== 16'd55) begin
      errors++;
      $display("FAIL stream_next: got %0d expected 55", addr_output);
    end
  endtask

  initial begin
    reset        = 1'b1;
    pattern_info = PAT;
    sprite_info  = '0;
    hcount       = '0;
    vcount       = '0;
    test_reset();
    test_basic();
    test_flip();
    test_scroll();
    test_row_boundary();
    test_col_boundary();
    test_visibility();
    test_zero_region();
    test_wrap_and_mask();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addr_cal_unit.md
ADDR_CAL_UNIT -- requirements
Module: addr_cal

Interface
REQ-001: clk  input  1  sole clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: pattern_info  input  80  tile pattern descriptor.
- [79:64] base_addr
- [63:48] tile_w
- [47:32] tile_h
- [31:16] region_w
- [15:0] region_h
REQ-004: sprite_info  input  32  sprite state.
- [31] visible
- [30] flipped
- [29:20] x origin
- [19:10] y origin
- [9:0] shift (horizontal scroll)
REQ-005: hcount  input  10  current pixel column.
REQ-006: vcount  input  10  current pixel row.
REQ-007: addr_output  output  16  pattern-memory pixel address for (hcount, vcount).
REQ-008: valid  output  1  high when the current pixel lies inside a visible sprite region.

Function
REQ-009: Both outputs SHALL be registered, with exactly 1 clk cycle latency from hcount/vcount/pattern_info/sprite_info to addr_output/valid.
REQ-010: The in-region test SHALL use 17-bit unsigned compares so that no term wraps:
- x <= hcount <= x + region_w - 1
- y <= vcount <= y + region_h - 1
REQ-011: valid SHALL equal visible AND in-region; region_w = 0 or region_h = 0 SHALL give valid = 0.
REQ-012: The local column SHALL be lc = (hcount - x + shift), computed in 16 bits with modulo-2^16 wrap.
REQ-013: The local row SHALL be lr = (vcount - y), computed in 16 bits.
REQ-014: Tile column SHALL be col = lc AND (tile_w - 1); tile row SHALL be row = lr AND (tile_h - 1).
- tile_w and tile_h are powers of two, 1..256.
- Non-power-of-two values still use this masking rule unchanged (no true modulo).
REQ-015: When flipped = 1, col SHALL be replaced by (tile_w - 1 - col); row is never flipped.
REQ-016: The computed address SHALL be addr = base_addr + row * tile_w + col, truncated to 16 bits (wrap-around).
REQ-017: When valid = 0, addr_output SHALL be 0x0000 on the same registered cycle.
REQ-018: The block SHALL be purely combinational-to-register with no internal state beyond the two output registers; input changes take effect on the next edge.
REQ-019: With flipped = 0, shift = 0 and x = 0, a column exactly at hcount = x + region_w - 1 SHALL be included; hcount = x + region_w SHALL be excluded. The same inclusive/exclusive rule applies to rows.

Reset
REQ-020: While reset = 1 at a rising edge, addr_output SHALL become 0x0000 and valid SHALL become 0, regardless of the inputs.
REQ-021: On the first edge after reset deasserts, the outputs SHALL reflect the inputs sampled at that edge, with no extra warm-up cycle.
REQ-022: Asserting reset mid-frame SHALL override any computation on that edge.

Verification
All scenarios use pattern_info = {0, 16, 16, 650, 32}.
REQ-023: Basic address.
- sprite: visible = 1, flipped = 0, x = 0, y = 368, shift = 0; hcount = 20, vcount = 370.
- Next cycle: valid = 1, addr_output = 36.
REQ-024: Flip.
- Same stimulus with flipped = 1.
- Next cycle: addr_output = 43 (col 11, row 2), valid = 1.
REQ-025: Scroll.
- shift = 5, hcount = 20, vcount = 370, flipped = 0.
- Next cycle: addr_output = 41.
- hcount = 0, shift = 0: addr_output = 32.
REQ-026: Row boundary.
- vcount = 399 -> valid = 1, addr_output = 244 (at hcount = 20).
- vcount = 400 -> valid = 0, addr_output = 0.
- vcount = 367 -> valid = 0.
REQ-027: Column boundary.
- hcount = 649 -> valid = 1.
- hcount = 650 -> valid = 0.
REQ-028: Visibility and reset.
- visible = 0 -> valid = 0, addr_output = 0.
- Assert reset for 1 cycle during a valid stream -> outputs 0/0 that cycle, then resume with 1-cycle latency.
